// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with sequential binary-to-BCD
// conversion, hex/decimal/signed display, leading-zero blanking,
// per-digit decimal points and an overflow flag.
module seg_scan_ctrl #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_W-1:0]     data,
  input  logic                  load,
  input  logic                  base,
  input  logic                  signed_en,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7:0]            digit_en,
  output logic [7:0]            sseg,
  output logic [7:0]            sseg1
);

  // Decimal digits needed for 2^DATA_W-1 is floor(DATA_W*log10(2))+1.
  localparam int BCD_N = (DATA_W * 30103) / 100000 + 1;
  localparam int BCD_W = 4 * BCD_N;
  // Nibble view wide enough for both the BCD result and all 8 digit slots.
  localparam int NIB_N = (BCD_N > 8) ? BCD_N : 8;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BC_W  = $clog2(DATA_W);

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h7E;  4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;  4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;  4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;  4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h7B;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;  4'hD: glyph = 7'h3D;
      4'hE: glyph = 7'h4F;  default: glyph = 7'h47;
    endcase
  endfunction

  logic              busy_q, done_q, ovf_q, neg_q, blz_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic [BCD_W-1:0]  bcd_q, bcd_adj, bcd_d;
  logic [6:0]        buf_q [8];
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        sel_q;
  logic [7:0]        en_q, sseg0_q, sseg1_q;

  logic              start, last, wr, data_neg;
  logic [4*NIB_N-1:0] src_vec;
  logic              c_neg, c_blank, c_ovf, top_nz;
  int                msd;
  logic [6:0]        c_buf [8];
  logic [7:0]        dp_pad;

  assign start    = load & ~busy_q;
  assign last     = busy_q & (bit_cnt_q == BC_W'(DATA_W - 1));
  assign wr       = busy_q ? last : (start & ~base);
  assign data_neg = signed_en & data[DATA_W-1];
  assign dp_pad   = 8'(dp_mask);

  // One shift-add-3 step: correct every nibble >= 5, then shift in the next MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BCD_W-2:0], sh_q[DATA_W-1]};
  end

  // Nibble source for the buffer write: final BCD result or raw hex nibbles.
  always_comb begin
    src_vec = '0;
    if (busy_q) src_vec[BCD_W-1:0] = bcd_d;
    else        src_vec[DATA_W-1:0] = data;
  end

  // Build the new display image: glyphs, blanking, minus placement, overflow.
  always_comb begin
    c_neg   = busy_q & neg_q;
    c_blank = busy_q ? blz_q : blank_lz;
    c_ovf   = 1'b0;
    msd     = 0;
    for (int i = 0; i < NIB_N; i++) begin
      if (src_vec[4*i +: 4] != 4'd0) begin
        if (i >= NUM_DIGITS) c_ovf = 1'b1;
        else                 msd = i;
      end
    end
    for (int i = 0; i < 8; i++) begin
      c_buf[i] = 7'h00;
      if (i < NUM_DIGITS && (!c_blank || i <= msd)) c_buf[i] = glyph(src_vec[4*i +: 4]);
    end
    top_nz = (src_vec[4*(NUM_DIGITS-1) +: 4] != 4'd0);
    // An already-overflowed magnitude has no free digit for the minus.
    if (c_neg && !c_ovf) begin
      if (c_blank) begin
        if (msd + 1 < NUM_DIGITS) begin
          for (int i = 0; i < 8; i++) begin
            if (i == msd + 1) c_buf[i] = 7'h01;
          end
        end else begin
          c_ovf = 1'b1;
        end
      end else if (top_nz) begin
        c_ovf = 1'b1;
      end else begin
        c_buf[NUM_DIGITS-1] = 7'h01;
      end
    end
  end

  // Capture on idle load, run the serial conversion, commit the display buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      blz_q     <= 1'b0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      bcd_q     <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= 7'h00;
    end else begin
      done_q <= wr;
      if (wr) begin
        ovf_q <= c_ovf;
        for (int i = 0; i < 8; i++) buf_q[i] <= c_buf[i];
      end
      if (start && base) begin
        busy_q    <= 1'b1;
        bit_cnt_q <= '0;
        bcd_q     <= '0;
        neg_q     <= data_neg;
        blz_q     <= blank_lz;
        sh_q      <= data_neg ? (~data) + DATA_W'(1) : data;
      end else if (busy_q) begin
        sh_q      <= {sh_q[DATA_W-2:0], 1'b0};
        bcd_q     <= bcd_d;
        bit_cnt_q <= bit_cnt_q + BC_W'(1);
        if (last) busy_q <= 1'b0;
      end
    end
  end

  // Scan timer and digit selector, wrapping at the last populated digit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sel_q <= 3'd0;
    end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
      cnt_q <= '0;
      sel_q <= (sel_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : sel_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered digit enable and segment banks; the idle bank is forced to 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q    <= 8'h00;
      sseg0_q <= 8'h00;
      sseg1_q <= 8'h00;
    end else begin
      en_q    <= 8'd1 << sel_q;
      sseg0_q <= sel_q[2] ? 8'h00 : {dp_pad[sel_q], buf_q[sel_q]};
      sseg1_q <= sel_q[2] ? {dp_pad[sel_q], buf_q[sel_q]} : 8'h00;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign digit_en = en_q;
  assign sseg     = sseg0_q;
  assign sseg1    = sseg1_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: an 8-digit and a 4-digit instance share
// the input stimulus; each test task checks its own expectations inline.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] data = '0;
  logic        load = 1'b0, base = 1'b0, signed_en = 1'b0, blank_lz = 1'b0;
  logic [7:0]  dp_mask = '0;

  logic       busy1, done1, ovf1;
  logic [7:0] en1, s0_1, s1_1;
  logic       busy2, done2, ovf2;
  logic [7:0] en2, s0_2, s1_2;

  int checks = 0;
  int failures = 0;

  logic [7:0] disp [8];
  logic [7:0] e [8];
  logic       bank_bad;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DATA_W(32), .NUM_DIGITS(8), .CLK_DIV(4)) u1 (
    .clk(clk), .rstn(rstn), .data(data), .load(load), .base(base),
    .signed_en(signed_en), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .busy(busy1), .done(done1), .ovf(ovf1), .digit_en(en1), .sseg(s0_1), .sseg1(s1_1));

  seg_scan_ctrl #(.DATA_W(32), .NUM_DIGITS(4), .CLK_DIV(4)) u2 (
    .clk(clk), .rstn(rstn), .data(data), .load(load), .base(base),
    .signed_en(signed_en), .blank_lz(blank_lz), .dp_mask(dp_mask[3:0]),
    .busy(busy2), .done(done2), .ovf(ovf2), .digit_en(en2), .sseg(s0_2), .sseg1(s1_2));

  // Observe a couple of scan rotations and record what each digit shows.
  task automatic scan_all(input int unit);
    logic [7:0] en, a, b, m;
    for (int d = 0; d < 8; d++) disp[d] = 8'hxx;
    bank_bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      en = (unit == 1) ? en1 : en2;
      a  = (unit == 1) ? s0_1 : s0_2;
      b  = (unit == 1) ? s1_1 : s1_2;
      for (int d = 0; d < 8; d++) begin
        m = 8'd1 << d;
        if (en == m) begin
          disp[d] = (d < 4) ? a : b;
          if (((d < 4) ? b : a) != 8'h00) bank_bad = 1'b1;
        end
      end
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic b, input logic s, input logic z);
    @(negedge clk);
    data = d; base = b; signed_en = s; blank_lz = z; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns the cycle (load cycle = 0) at which done1 is seen and busy1 cycles before it.
  task automatic wait_done1(output int cyc, output int bc);
    cyc = 1; bc = 0;
    while (!done1 && cyc < 60) begin
      if (busy1) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] ex;
    #12;
    checks++;
    if ({busy1, done1, ovf1, en1, s0_1, s1_1} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {busy1, done1, ovf1, en1, s0_1, s1_1});
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (en1 !== 8'h00) begin failures++; $display("FAIL reset_en_first got=%h exp=00", en1); end
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      ex = 8'd1 << ((k / 4) % 8);
      checks++;
      if (en1 !== ex) begin failures++; $display("FAIL scan_en k=%0d got=%h exp=%h", k, en1, ex); end
      checks++;
      if ((s0_1 | s1_1) !== 8'h00) begin
        failures++; $display("FAIL scan_blank k=%0d got=%h/%h exp=00", k, s0_1, s1_1);
      end
    end
  endtask

  task automatic test_decimal();
    int cyc, bc;
    do_load(32'd12345, 1'b1, 1'b0, 1'b1);
    wait_done1(cyc, bc);
    checks++;
    if (cyc != 33) begin failures++; $display("FAIL dec_latency got=%0d exp=33", cyc); end
    checks++;
    if (bc != 32) begin failures++; $display("FAIL dec_busy_cycles got=%0d exp=32", bc); end
    checks++;
    if ({busy1, ovf1} !== 2'b00) begin failures++; $display("FAIL dec_busy_ovf got=%b exp=00", {busy1, ovf1}); end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin failures++; $display("FAIL dec_done_pulse got=%b exp=0", done1); end
    scan_all(1);
    e = '{8'h5B, 8'h33, 8'h79, 8'h6D, 8'h30, 8'h00, 8'h00, 8'h00};
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (disp[d] !== e[d]) begin failures++; $display("FAIL dec_digit%0d got=%h exp=%h", d, disp[d], e[d]); end
    end
    checks++;
    if (bank_bad !== 1'b0) begin failures++; $display("FAIL dec_idle_bank got=%b exp=0", bank_bad); end
  endtask

  task automatic test_signed();
    int cyc, bc;
    // -7 with blanking: minus sits just left of the 7.
    do_load(32'hFFFF_FFF9, 1'b1, 1'b1, 1'b1);
    wait_done1(cyc, bc);
    checks++;
    if (ovf1 !== 1'b0) begin failures++; $display("FAIL neg7_ovf got=%b exp=0", ovf1); end
    scan_all(1);
    e = '{8'h70, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (disp[d] !== e[d]) begin failures++; $display("FAIL neg7_digit%0d got=%h exp=%h", d, disp[d], e[d]); end
    end
    // -7 without blanking: zeros fill, minus takes the top digit.
    do_load(32'hFFFF_FFF9, 1'b1, 1'b1, 1'b0);
    wait_done1(cyc, bc);
    checks++;
    if (ovf1 !== 1'b0) begin failures++; $display("FAIL neg7nlz_ovf got=%b exp=0", ovf1); end
    scan_all(1);
    e = '{8'h70, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h01};
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (disp[d] !== e[d]) begin failures++; $display("FAIL neg7nlz_digit%0d got=%h exp=%h", d, disp[d], e[d]); end
    end
    // -12345678 fills all 8 digits: no room for the minus.
    do_load(32'hFF43_9EB2, 1'b1, 1'b1, 1'b1);
    wait_done1(cyc, bc);
    checks++;
    if (ovf1 !== 1'b1) begin failures++; $display("FAIL negfull_ovf got=%b exp=1", ovf1); end
    scan_all(1);
    checks++;
    if ({disp[7], disp[0]} !== 16'h307F) begin
      failures++; $display("FAIL negfull_digits got=%h exp=307F", {disp[7], disp[0]});
    end
    // Zero with blanking still shows a single 0.
    do_load(32'd0, 1'b1, 1'b0, 1'b1);
    wait_done1(cyc, bc);
    scan_all(1);
    checks++;
    if ({disp[1], disp[0]} !== 16'h007E) begin
      failures++; $display("FAIL zero_digits got=%h exp=007E", {disp[1], disp[0]});
    end
  endtask

  task automatic test_hex();
    dp_mask = 8'h01;
    do_load(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({done1, busy1} !== 2'b10) begin failures++; $display("FAIL hex_done_busy got=%b exp=10", {done1, busy1}); end
    @(negedge clk);
    checks++;
    if ({done1, busy1, ovf1} !== 3'b000) begin
      failures++; $display("FAIL hex_after got=%b exp=000", {done1, busy1, ovf1});
    end
    scan_all(1);
    // Nibbles F,E,E,B,D,A,E,D from digit 0 upward; digit 0 carries the dp.
    e = '{8'hC7, 8'h4F, 8'h4F, 8'h1F, 8'h3D, 8'h77, 8'h4F, 8'h3D};
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (disp[d] !== e[d]) begin failures++; $display("FAIL hex_digit%0d got=%h exp=%h", d, disp[d], e[d]); end
    end
    dp_mask = 8'h00;
    do_load(32'h0000_00A0, 1'b0, 1'b0, 1'b1);
    scan_all(1);
    checks++;
    if ({disp[2], disp[1], disp[0]} !== 24'h00777E) begin
      failures++; $display("FAIL hex_blank got=%h exp=00777E", {disp[2], disp[1], disp[0]});
    end
    // Five significant nibbles overflow only the 4-digit instance.
    do_load(32'h0001_2345, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({ovf2, ovf1} !== 2'b10) begin failures++; $display("FAIL hex_ovf got=%b exp=10", {ovf2, ovf1}); end
  endtask

  task automatic test_back_to_back();
    int cyc, ndone, first, wraps;
    logic [7:0] prev;
    do_load(32'd123456, 1'b1, 1'b0, 1'b1);
    cyc = 1; ndone = 0; first = -1;
    while (cyc < 60) begin
      if (done2) begin ndone++; if (first < 0) first = cyc; end
      if (cyc == 10) begin data = 32'd7; load = 1'b1; end
      if (cyc == 11) load = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ndone != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", ndone); end
    checks++;
    if (first != 33) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=33", first); end
    checks++;
    if (ovf2 !== 1'b1) begin failures++; $display("FAIL b2b_ovf got=%b exp=1", ovf2); end
    scan_all(2);
    e = '{8'h5F, 8'h5B, 8'h33, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (disp[d] !== e[d]) begin failures++; $display("FAIL b2b_digit%0d got=%h exp=%h", d, disp[d], e[d]); end
    end
    wraps = 0; bank_bad = 1'b0;
    prev = en2;
    repeat (40) begin
      @(negedge clk);
      if (s1_2 !== 8'h00 || en2[7:4] !== 4'h0) bank_bad = 1'b1;
      if (prev == 8'h08 && en2 != 8'h08) begin
        checks++;
        if (en2 !== 8'h01) begin failures++; $display("FAIL b2b_wrap got=%h exp=01", en2); end
        wraps++;
      end
      prev = en2;
    end
    checks++;
    if (wraps < 2) begin failures++; $display("FAIL b2b_wrap_seen got=%0d exp>=2", wraps); end
    checks++;
    if (bank_bad !== 1'b0) begin failures++; $display("FAIL b2b_bank1 got=%b exp=0", bank_bad); end
  endtask

  task automatic test_reset_mid();
    int cyc, bc, ndone;
    do_load(32'd12345, 1'b1, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, ovf1, en1, s0_1, s1_1} !== 27'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h exp=0", {busy1, done1, ovf1, en1, s0_1, s1_1});
    end
    @(negedge clk);
    rstn = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
    scan_all(1);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (disp[d] !== 8'h00) begin failures++; $display("FAIL midrst_digit%0d got=%h exp=00", d, disp[d]); end
    end
    do_load(32'd12345, 1'b1, 1'b0, 1'b1);
    wait_done1(cyc, bc);
    checks++;
    if (cyc != 33) begin failures++; $display("FAIL midrst_reload_latency got=%0d exp=33", cyc); end
    scan_all(1);
    checks++;
    if ({disp[4], disp[0]} !== 16'h305B) begin
      failures++; $display("FAIL midrst_reload_digits got=%h exp=305B", {disp[4], disp[0]});
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_signed();
    test_hex();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
